piso4: RTL

Parallel-in/serial-out framing stage that consumes the 4-bit word held by the upstream flop register and sends it out on a single line. Each accepted word goes out as one frame: start bit, data LSB first, optional parity bit, stop bit. Each bit is held for a programmable number of clocks. A valid/ready handshake on the parallel side lets the upstream stage present a new word as soon as the previous frame completes.

---
 rtl/piso4.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/piso4.sv
// piso4: frames an accepted parallel word as start, data LSB-first,
// optional parity and stop bits, each held for DIV clocks.
module piso4 #(
    parameter int W         = 4,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1,
    parameter int ODD       = 0
) (
    input  logic         c,
    input  logic         r,
    input  logic [W-1:0] d,
    input  logic         load,
    output logic         ready,
    output logic         so,
    output logic         busy,
    output logic         done
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          par_q, par_d;
    logic          so_q, so_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          tick;

    assign tick  = (div_q == DIV_LAST);
    assign so    = so_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign ready = ready_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        so_d    = so_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                so_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                div_d   = '0;
                bit_d   = '0;
                if (load) begin
                    sh_d    = d;
                    par_d   = (^d) ^ (ODD != 0);
                    state_d = START;
                    ready_d = 1'b0;
                end
            end
            START: begin
                // first START cycle only arms the line; bit timing starts here
                if (!busy_q) begin
                    busy_d = 1'b1;
                    so_d   = 1'b0;
                    div_d  = '0;
                end else if (tick) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    so_d    = sh_q[0];
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DATA: begin
                if (!tick) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            so_d    = par_q;
                        end else begin
                            state_d = STOP;
                            so_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        sh_d  = sh_q >> 1;
                        so_d  = sh_d[0];
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d   = '0;
                    state_d = STOP;
                    so_d    = 1'b1;
                end
            end
            STOP: begin
                if (!tick) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d   = '0;
                    state_d = IDLE;
                    so_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                so_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (!r) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

endmodule
